// File: rtl/bpsk_burst_ctrl.sv
// Burst scheduler for the BPSK transmit chain: preamble, PN payload, zero tail, guard gap.
// Generates the symbol strobe, m_seq enable, source select and TX gate as registered Moore outputs.
module bpsk_burst_ctrl #(
  parameter int SYM_DIV  = 50,
  parameter int PRE_LEN  = 16,
  parameter int TAIL_LEN = 8,
  parameter int GAP_LEN  = 4,
  parameter int LEN_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  output logic             busy,
  output logic             sym_en,
  output logic             seq_en,
  output logic             pre_bit,
  output logic [1:0]       data_sel,
  output logic             tx_gate,
  output logic             done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DIV_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam int CNT_W = max2(LEN_W, max2($clog2(PRE_LEN + 1),
                                          max2($clog2(TAIL_LEN + 1), $clog2(GAP_LEN + 1))));

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAYLOAD,
    S_TAIL,
    S_GAP
  } state_t;

  state_t             state, nxt_state;
  logic [DIV_W-1:0]   div, nxt_div;
  logic [CNT_W-1:0]   cnt, nxt_cnt, lim;
  logic [LEN_W-1:0]   len_q, nxt_len;
  logic               nxt_done;
  logic               nxt_active;

  // Symbol count limit of the current state (N-1); PAYLOAD is never entered with len_q==0.
  always_comb begin
    lim = '0;
    case (state)
      S_PRE:     lim = CNT_W'(PRE_LEN - 1);
      S_PAYLOAD: lim = CNT_W'(len_q) - CNT_W'(1);
      S_TAIL:    lim = CNT_W'(TAIL_LEN - 1);
      S_GAP:     lim = CNT_W'(GAP_LEN - 1);
      default:   lim = '0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_div   = div;
    nxt_cnt   = cnt;
    nxt_len   = len_q;
    nxt_done  = 1'b0;
    if (state == S_IDLE) begin
      if (start) begin
        nxt_state = S_PRE;
        nxt_len   = payload_len;
        nxt_div   = '0;
        nxt_cnt   = '0;
      end
    end else if (div == DIV_W'(SYM_DIV - 1)) begin
      nxt_div = '0;
      if (cnt == lim) begin
        nxt_cnt = '0;
        case (state)
          S_PRE:     nxt_state = (len_q == '0) ? S_TAIL : S_PAYLOAD;
          S_PAYLOAD: nxt_state = S_TAIL;
          S_TAIL:    nxt_state = S_GAP;
          S_GAP: begin
            nxt_state = S_IDLE;
            nxt_done  = 1'b1;
          end
          default:   nxt_state = S_IDLE;
        endcase
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end else begin
      nxt_div = div + DIV_W'(1);
    end
  end

  assign nxt_active = (nxt_state == S_PRE) || (nxt_state == S_PAYLOAD) || (nxt_state == S_TAIL);

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      sym_en   <= 1'b0;
      seq_en   <= 1'b0;
      pre_bit  <= 1'b0;
      data_sel <= 2'b00;
      tx_gate  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      div      <= nxt_div;
      cnt      <= nxt_cnt;
      len_q    <= nxt_len;
      busy     <= (nxt_state != S_IDLE);
      sym_en   <= nxt_active && (nxt_div == '0);
      seq_en   <= (nxt_state == S_PAYLOAD) && (nxt_div == '0);
      pre_bit  <= (nxt_state == S_PRE) && !nxt_cnt[0];
      data_sel <= (nxt_state == S_PRE)     ? 2'b01 :
                  (nxt_state == S_PAYLOAD) ? 2'b10 : 2'b00;
      tx_gate  <= nxt_active;
      done     <= nxt_done;
    end
  end

endmodule

// File: tb/tb_bpsk_burst_ctrl.sv
// Directed bench for bpsk_burst_ctrl with small parameters; expected outputs are derived
// from the cycle index inside each burst.
module tb_bpsk_burst_ctrl;

  localparam int SYM_DIV  = 4;
  localparam int PRE_LEN  = 4;
  localparam int TAIL_LEN = 2;
  localparam int GAP_LEN  = 1;
  localparam int LEN_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] payload_len = '0;
  logic             busy, sym_en, seq_en, pre_bit, tx_gate, done;
  logic [1:0]       data_sel;

  int n_total = 0;
  int n_bad   = 0;

  bpsk_burst_ctrl #(
    .SYM_DIV(SYM_DIV), .PRE_LEN(PRE_LEN), .TAIL_LEN(TAIL_LEN),
    .GAP_LEN(GAP_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .payload_len(payload_len),
    .busy(busy), .sym_en(sym_en), .seq_en(seq_en), .pre_bit(pre_bit),
    .data_sel(data_sel), .tx_gate(tx_gate), .done(done)
  );

  always #5 clk = ~clk;

  // {busy, sym_en, seq_en, pre_bit, data_sel, tx_gate, done}
  function automatic logic [7:0] obs_vec();
    return {busy, sym_en, seq_en, pre_bit, data_sel, tx_gate, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests a burst of len symbols and checks every cycle up to and including the done cycle.
  task automatic burst(input int len, input bit hold, input int chg_at, input int chg_len);
    int total, n_seq, n_sym, sym, d;
    logic [7:0] exp;
    bit pre, pay, tail, gap;
    total = (PRE_LEN + len + TAIL_LEN + GAP_LEN) * SYM_DIV;
    n_seq = 0;
    n_sym = 0;
    start = 1'b1;
    payload_len = LEN_W'(len);
    tick();
    if (!hold) start = 1'b0;
    for (int c = 0; c < total; c++) begin
      sym  = c / SYM_DIV;
      d    = c % SYM_DIV;
      pre  = (sym < PRE_LEN);
      pay  = !pre && (sym < PRE_LEN + len);
      tail = !pre && !pay && (sym < PRE_LEN + len + TAIL_LEN);
      gap  = !pre && !pay && !tail;
      exp[7]   = 1'b1;
      exp[6]   = !gap && (d == 0);
      exp[5]   = pay && (d == 0);
      exp[4]   = pre && (sym % 2 == 0);
      exp[3:2] = pre ? 2'b01 : (pay ? 2'b10 : 2'b00);
      exp[1]   = !gap;
      exp[0]   = 1'b0;
      check($sformatf("len%0d_c%0d", len, c), 32'(obs_vec()), 32'(exp));
      n_seq += int'(seq_en);
      n_sym += int'(sym_en);
      if (c == chg_at) payload_len = LEN_W'(chg_len);
      tick();
    end
    check($sformatf("len%0d_done", len), 32'(obs_vec()), 32'h01);
    check($sformatf("len%0d_seq_cnt", len), 32'(n_seq), 32'(len));
    check($sformatf("len%0d_sym_cnt", len), 32'(n_sym), 32'(PRE_LEN + len + TAIL_LEN));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'(obs_vec()), 32'h00);
    rst_n = 1'b1;
    tick();
    repeat (3) begin
      check("idle_outputs", 32'(obs_vec()), 32'h00);
      tick();
    end

    // Nominal burst, then quiet idle
    burst(3, 1'b0, -1, 0);
    tick();
    check("idle_after_done", 32'(obs_vec()), 32'h00);
    tick();

    // Empty payload: PRE goes straight to TAIL
    burst(0, 1'b0, -1, 0);
    tick();

    // Start held high: one burst in flight, second accepted on the done cycle
    burst(2, 1'b1, -1, 0);
    burst(2, 1'b0, -1, 0);
    tick();
    check("idle_after_b2b", 32'(obs_vec()), 32'h00);

    // payload_len changed mid-burst must not affect the latched length
    burst(5, 1'b0, 10, 9);
    tick();

    // Reset during PAYLOAD
    start = 1'b1;
    payload_len = 8'd3;
    tick();
    start = 1'b0;
    repeat (PRE_LEN * SYM_DIV + 2) tick();
    check("in_payload_before_rst", 32'(data_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_same_cycle", 32'(obs_vec()), 32'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("idle_after_rst", 32'(obs_vec()), 32'h00);
      tick();
    end

    // Longest payload
    burst(255, 1'b0, -1, 0);
    tick();
    check("idle_final", 32'(obs_vec()), 32'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
